vrbridge_chk: RTL

VRBRIDGE_CHK -- requirements
Module: vrbridge_chk

---
 rtl/vrbridge_chk.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vrbridge_chk.sv
// vrbridge_chk: Avalon-ST video bridge checker.
// Strips the packet type beat from video packets and passes raw pixels
// straight through with zero latency. Control packets are decoded into a
// committed frame header. Each video packet's pixel count is checked against
// the size that header implies, and over-length frames are optionally truncated.
module vrbridge_chk #(
    parameter int COLOR_BITS   = 8,
    parameter int COLOR_PLANES = 3,
    parameter int DATA_WIDTH   = 24,
    parameter int REQUIRE_CTRL = 1,
    parameter int TRUNCATE     = 1
) (
    input  logic                  clk,
    input  logic                  global_rst_n,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_valid,
    input  logic                  din_startofpacket,
    input  logic                  din_endofpacket,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    input  logic                  dout_ready,
    output logic [15:0]           im_width,
    output logic [15:0]           im_height,
    output logic [3:0]            im_interlaced,
    output logic                  hdr_valid,
    output logic                  frame_done,
    output logic                  short_err,
    output logic                  long_err,
    output logic                  ctrl_err,
    output logic [31:0]           last_pix_cnt,
    output logic [15:0]           frame_cnt
);

    localparam logic [3:0] TYPE_VIDEO = 4'h0;
    localparam logic [3:0] TYPE_CTRL  = 4'hF;
    // nine header nibbles: 4 width, 4 height, 1 interlace
    localparam logic [4:0] NIB_FULL   = 5'd9;
    localparam logic [4:0] NIB_STEP   = 5'(COLOR_PLANES);

    typedef enum logic [1:0] {IDLE, HEAD, DATA, DISCARD} state_t;

    state_t                        state, state_nx;
    logic                          acc;
    logic [3:0]                    pkt_type;
    logic                          video_ok;

    // header capture
    logic [COLOR_PLANES-1:0][3:0]  plane_nib;
    logic [8:0][3:0]               shadow, shadow_nx;
    logic [4:0]                    nib_cnt, nib_nx;

    // frame accounting
    logic [31:0]                   pix_cnt, pix_inc, exp_frame, exp_now;
    logic [32:0]                   pix_sum;
    logic [16:0]                   h_adj, h_sel;
    logic                          truncated, first_pix, trunc_hit;
    logic [31:0]                   fin_cnt, fin_exp;
    logic                          fin;

    // FSM event strobes
    logic start_video, zero_frame, frame_end, hdr_commit, hdr_fail, enter_trunc;

    assign acc      = din_valid & din_ready;
    assign pkt_type = din_data[3:0];
    assign video_ok = (REQUIRE_CTRL == 0) || hdr_valid;

    // low nibble of each colour symbol carries one header nibble
    for (genvar p = 0; p < COLOR_PLANES; p++) begin : g_plane
        assign plane_nib[p] = din_data[p*COLOR_BITS +: 4];
    end

    // passthrough: pixels flow combinationally only while in DATA
    assign din_ready          = (state == DATA) ? dout_ready : 1'b1;
    assign dout_data          = din_data;
    assign dout_valid         = din_valid & (state == DATA);
    assign dout_startofpacket = dout_valid & first_pix;
    assign dout_endofpacket   = dout_valid & (din_endofpacket | trunc_hit);

    // saturating pixel count including the beat currently presented
    assign pix_sum   = {1'b0, pix_cnt} + 33'd1;
    assign pix_inc   = pix_sum[32] ? 32'hFFFF_FFFF : pix_sum[31:0];
    assign trunc_hit = (TRUNCATE != 0) && (pix_inc >= exp_frame);

    // expected pixels from the committed header; interlaced frames carry one
    // field, the odd line going to the field flagged by interlace bit 2 clear
    assign h_adj   = {1'b0, im_height} + {16'd0, ~im_interlaced[2]};
    assign h_sel   = im_interlaced[3] ? (h_adj >> 1) : {1'b0, im_height};
    assign exp_now = 32'(im_width) * 32'(h_sel);

    // end-of-frame summary: normal/truncated end, or a zero-pixel packet
    assign fin     = frame_end | zero_frame;
    assign fin_cnt = frame_end ? pix_inc : 32'd0;
    assign fin_exp = frame_end ? exp_frame : exp_now;

    // header nibbles of the current beat merged over the shadow copy
    always_comb begin
        shadow_nx = shadow;
        nib_nx    = nib_cnt;
        if (state == HEAD && acc) begin
            for (int p = 0; p < COLOR_PLANES; p++) begin
                if ((nib_cnt + 5'(p)) < NIB_FULL)
                    shadow_nx[4'(nib_cnt + 5'(p))] = plane_nib[p];
            end
            nib_nx = ((nib_cnt + NIB_STEP) >= NIB_FULL) ? NIB_FULL : (nib_cnt + NIB_STEP);
        end
    end

    // next state and per-beat events
    always_comb begin
        state_nx    = state;
        start_video = 1'b0;
        zero_frame  = 1'b0;
        frame_end   = 1'b0;
        hdr_commit  = 1'b0;
        hdr_fail    = 1'b0;
        enter_trunc = 1'b0;
        case (state)
            IDLE: begin
                if (acc && din_startofpacket) begin
                    if (pkt_type == TYPE_CTRL) begin
                        // a control packet with no payload carries no nibbles
                        if (din_endofpacket) hdr_fail = 1'b1;
                        else                 state_nx = HEAD;
                    end else if (pkt_type == TYPE_VIDEO && video_ok) begin
                        if (din_endofpacket) begin
                            zero_frame = 1'b1;
                        end else begin
                            state_nx    = DATA;
                            start_video = 1'b1;
                        end
                    end else if (!din_endofpacket) begin
                        state_nx = DISCARD;
                    end
                end
            end
            HEAD: begin
                if (acc && din_endofpacket) begin
                    state_nx = IDLE;
                    if (nib_nx == NIB_FULL) hdr_commit = 1'b1;
                    else                    hdr_fail   = 1'b1;
                end
            end
            DATA: begin
                if (acc) begin
                    if (din_endofpacket) begin
                        state_nx  = IDLE;
                        frame_end = 1'b1;
                    end else if (trunc_hit) begin
                        state_nx    = DISCARD;
                        enter_trunc = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (acc && din_endofpacket) begin
                    state_nx  = IDLE;
                    frame_end = truncated;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) state <= IDLE;
        else               state <= state_nx;
    end

    // header shadow capture; nibble counter only live inside a control packet
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            shadow  <= '0;
            nib_cnt <= '0;
        end else begin
            shadow  <= shadow_nx;
            nib_cnt <= (state == HEAD) ? nib_nx : 5'd0;
        end
    end

    // committed header, updated only at a complete control packet's end
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            im_width      <= '0;
            im_height     <= '0;
            im_interlaced <= '0;
            hdr_valid     <= 1'b0;
        end else if (hdr_commit) begin
            im_width      <= {shadow_nx[0], shadow_nx[1], shadow_nx[2], shadow_nx[3]};
            im_height     <= {shadow_nx[4], shadow_nx[5], shadow_nx[6], shadow_nx[7]};
            im_interlaced <= shadow_nx[8];
            hdr_valid     <= 1'b1;
        end
    end

    // per-frame tracking: pixel count, latched expectation, SOP and truncation flags
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            pix_cnt   <= '0;
            exp_frame <= '0;
            truncated <= 1'b0;
            first_pix <= 1'b0;
        end else begin
            if (start_video)
                pix_cnt <= '0;
            else if (acc && (state == DATA || (state == DISCARD && truncated)))
                pix_cnt <= pix_inc;

            // expectation frozen at packet start so a later header cannot move it
            if (start_video) exp_frame <= exp_now;

            if (enter_trunc)            truncated <= 1'b1;
            else if (state_nx == IDLE)  truncated <= 1'b0;

            if (start_video)                first_pix <= 1'b1;
            else if (state == DATA && acc)  first_pix <= 1'b0;
        end
    end

    // single-cycle status pulses and completed-frame statistics
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            frame_done   <= 1'b0;
            short_err    <= 1'b0;
            long_err     <= 1'b0;
            ctrl_err     <= 1'b0;
            last_pix_cnt <= '0;
            frame_cnt    <= '0;
        end else begin
            frame_done <= fin;
            short_err  <= fin && (fin_cnt < fin_exp);
            long_err   <= fin && (fin_cnt > fin_exp);
            ctrl_err   <= hdr_fail;
            if (fin) begin
                last_pix_cnt <= fin_cnt;
                frame_cnt    <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
